// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-advance enable in, counters/flags/syncs out.
interface vga_timing_gen_if;
  logic        en;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    input  en,
    output hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start
  );

  modport slave (
    output en,
    input  hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v pixel counters, blanking flags, sync pulses and
// a frame_start pulse. Flags are decoded from the next counter values so they
// line up with the counters they describe in the same cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds carry one extra bit so window ends equal to 2048/1024 do not
  // truncate to zero.
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] HB_BEG  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] VB_BEG  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hc_nxt;
  logic [9:0]  vcount_q, vc_nxt;
  logic        hblnk_q, vblnk_q, hsync_q, vsync_q, fs_q;
  logic        h_wrap, v_wrap;
  logic        hb_nxt, vb_nxt, hs_nxt, vs_nxt;

  // Next counter values and flag decode; >= wrap also recovers from upsets.
  always_comb begin
    h_wrap = ({1'b0, hcount_q} >= H_LAST);
    v_wrap = ({1'b0, vcount_q} >= V_LAST);
    hc_nxt = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vc_nxt = vcount_q;
    if (h_wrap) vc_nxt = v_wrap ? 10'd0 : vcount_q + 10'd1;
    hb_nxt = ({1'b0, hc_nxt} >= HB_BEG);
    vb_nxt = ({1'b0, vc_nxt} >= VB_BEG);
    hs_nxt = (({1'b0, hc_nxt} >= HS_BEG) && ({1'b0, hc_nxt} < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt = (({1'b0, vc_nxt} >= VS_BEG) && ({1'b0, vc_nxt} < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Counter/flag registers; hold on stall, frame_start only on an enabled wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      fs_q     <= 1'b0;
    end else if (vif.en) begin
      hcount_q <= hc_nxt;
      vcount_q <= vc_nxt;
      hblnk_q  <= hb_nxt;
      vblnk_q  <= vb_nxt;
      hsync_q  <= hs_nxt;
      vsync_q  <= vs_nxt;
      fs_q     <= h_wrap && v_wrap;
    end else begin
      fs_q     <= 1'b0;
    end
  end

  assign vif.hcount      = hcount_q;
  assign vif.vcount      = vcount_q;
  assign vif.hblnk       = hblnk_q;
  assign vif.vblnk       = vblnk_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-geometry instance for reset, line boundaries and
// async reset; a small-geometry, positive-polarity instance for frame wrap,
// frame_start and enable stalls.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  int   passed = 0, total = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();

  vga_timing_gen d0 (.clk(clk), .rst(rst0), .vif(if0.master));

  // 15 pixels/line (active 8, sync 10..12), 8 lines/frame (active 4, sync 5..6)
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) d1 (.clk(clk), .rst(rst1), .vif(if1.master));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // expected state of d1
  int eh = 0, ev = 0, efs = 0;

  task automatic step1(input bit en);
    if (en) begin
      efs = (eh == 14 && ev == 7) ? 1 : 0;
      if (eh == 14) begin
        eh = 0;
        ev = (ev == 7) ? 0 : ev + 1;
      end else eh = eh + 1;
    end else efs = 0;
  endtask

  task automatic chk1(input string ph);
    chk({ph, "_h"},  int'(if1.hcount), eh);
    chk({ph, "_v"},  int'(if1.vcount), ev);
    chk({ph, "_hb"}, int'(if1.hblnk), (eh >= 8) ? 1 : 0);
    chk({ph, "_vb"}, int'(if1.vblnk), (ev >= 4) ? 1 : 0);
    chk({ph, "_hs"}, int'(if1.hsync), (eh >= 10 && eh < 13) ? 1 : 0);
    chk({ph, "_vs"}, int'(if1.vsync), (ev >= 5 && ev < 7) ? 1 : 0);
    chk({ph, "_fs"}, int'(if1.frame_start), efs);
  endtask

  initial begin
    int h, v, pulses;
    bit found;
    if0.en = 1'b1;
    if1.en = 1'b1;

    // reset held for 5 cycles with en=1
    repeat (5) @(negedge clk);
    chk("rst_h",  int'(if0.hcount), 0);
    chk("rst_v",  int'(if0.vcount), 0);
    chk("rst_hb", int'(if0.hblnk), 0);
    chk("rst_vb", int'(if0.vblnk), 0);
    chk("rst_hs", int'(if0.hsync), 1);
    chk("rst_vs", int'(if0.vsync), 1);
    chk("rst_fs", int'(if0.frame_start), 0);
    chk("rst_pol_hs", int'(if1.hsync), 0);
    chk("rst_pol_vs", int'(if1.vsync), 0);

    // one full line plus the wrap into line 1
    rst0 = 1'b0;
    for (int k = 1; k <= 1346; k++) begin
      @(negedge clk);
      h = k % 1344;
      v = k / 1344;
      chk("line_h",  int'(if0.hcount), h);
      chk("line_v",  int'(if0.vcount), v);
      chk("line_hb", int'(if0.hblnk), (h >= 1024) ? 1 : 0);
      chk("line_hs", int'(if0.hsync), (h >= 1048 && h < 1184) ? 0 : 1);
      chk("line_vb", int'(if0.vblnk), 0);
      chk("line_vs", int'(if0.vsync), 1);
      chk("line_fs", int'(if0.frame_start), 0);
    end

    // async reset mid-line at hcount=500
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (if0.hcount == 11'd500) found = 1'b1;
    end
    chk("wait_500", int'(found), 1);
    #1 rst0 = 1'b1;
    #1;
    chk("arst_h",  int'(if0.hcount), 0);
    chk("arst_v",  int'(if0.vcount), 0);
    chk("arst_hs", int'(if0.hsync), 1);
    @(negedge clk);
    rst0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("rel_h",  int'(if0.hcount), k);
      chk("rel_v",  int'(if0.vcount), 0);
      chk("rel_fs", int'(if0.frame_start), 0);
    end

    // small instance: two full frames, positive sync polarity
    rst1 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 240; k++) begin
      if1.en = 1'b1;
      @(negedge clk);
      step1(1'b1);
      chk1("frm");
      if (if1.frame_start) pulses++;
    end
    chk("frm_pulses", pulses, 2);

    // en one cycle on, two off, across a frame wrap
    pulses = 0;
    for (int k = 0; k < 400; k++) begin
      if1.en = (k % 3 == 0);
      @(negedge clk);
      step1(k % 3 == 0);
      chk1("stall");
      if (if1.frame_start) pulses++;
    end
    chk("stall_pulses", pulses, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
